// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl_pkg
// Brief    : Shared constants and types for the pipeline stall controller:
//            FSM state encoding, load-stall counter limits, the canonical NOP
//            and the per-stage enable/flush control bundle.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

  // FSM state encoding (2'b11 is illegal and recovers to RUN)
  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_MDU_WAIT   = 2'b10;

  // Legal range of bubbles per load-use request and the counter that tracks them
  localparam int STALL_MIN_CYCLES = 1;
  localparam int STALL_MAX_CYCLES = 4;
  localparam int STALL_CTR_W      = 2;

  // Canonical RV32I NOP (addi x0, x0, 0) loaded by the flush controls
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Per-stage enable/flush bundle, MSB first
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_flush;
  } stage_ctrl_t;

  // Free-flowing pipeline: everything enabled, nothing flushed
  localparam stage_ctrl_t CTRL_FLOW   = 6'b110100;
  // Branch redirect: squash the wrong-path instructions in IF/ID and ID/EX
  localparam stage_ctrl_t CTRL_BRANCH = 6'b111110;
  // MDU busy: freeze PC..ID/EX, send bubbles downstream of EX
  localparam stage_ctrl_t CTRL_MDU    = 6'b000001;
  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX
  localparam stage_ctrl_t CTRL_LOAD   = 6'b000110;
  // Reset held: nothing advances, every stage reads as a NOP
  localparam stage_ctrl_t CTRL_RESET  = 6'b001111;

endpackage : pipeline_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that saturates at all-ones instead of wrapping, with
//            a synchronous clear that takes precedence over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Converts load-use bubble requests, MDU busy periods and EX-stage
//            branch redirects into per-stage enables/flushes, issues the
//            one-cycle WB forward selects for the instruction released after
//            a load-use stall, and counts stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             BUBBLE_REQ,
  input  logic             FRWD_RS1_WB_REQ,
  input  logic             FRWD_RS2_WB_REQ,
  input  logic             MDU_START,
  input  logic             MDU_DONE,
  input  logic             BRANCH_TAKEN,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_EN,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic             FRWD_RS1_WB,
  output logic             FRWD_RS2_WB,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [1:0]       STATE
);

  // Out-of-range settings are clamped into the supported 1..4 window
  localparam int LS_EFF =
      (LOAD_STALL_CYCLES < STALL_MIN_CYCLES) ? STALL_MIN_CYCLES :
      (LOAD_STALL_CYCLES > STALL_MAX_CYCLES) ? STALL_MAX_CYCLES :
      LOAD_STALL_CYCLES;
  // Remaining LOAD_STALL cycles after the request cycle itself
  localparam logic [STALL_CTR_W-1:0] LS_LOAD = STALL_CTR_W'(LS_EFF - 1);

  logic [1:0]             state_q, state_d;
  logic [STALL_CTR_W-1:0] bcnt_q,  bcnt_d;
  logic [1:0]             hold_q,  hold_d;   // {rs1, rs2} captured forward requests
  logic [1:0]             frwd_q,  frwd_d;   // {rs1, rs2} registered forward selects
  stage_ctrl_t            ctrl_run;          // controls while out of reset
  stage_ctrl_t            ctrl;              // controls actually driven
  logic                   arm;
  logic [1:0]             arm_val;
  logic [CNT_W-1:0]       stall_cnt;

  // Next-state, stage controls and forward arming from state and hazard inputs
  always_comb begin
    ctrl_run = CTRL_FLOW;
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    hold_d   = hold_q;
    arm      = 1'b0;
    arm_val  = hold_q;
    case (state_q)
      ST_RUN: begin
        if (BRANCH_TAKEN) begin
          // ID holds a wrong-path instruction, so its hazards are moot
          ctrl_run = CTRL_BRANCH;
        end else if (MDU_START && !MDU_DONE) begin
          ctrl_run = CTRL_MDU;
          state_d  = ST_MDU_WAIT;
        end else if (MDU_START) begin
          // Single-cycle MDU result: no stall needed
          ctrl_run = CTRL_FLOW;
        end else if (BUBBLE_REQ) begin
          ctrl_run = CTRL_LOAD;
          hold_d   = {FRWD_RS1_WB_REQ, FRWD_RS2_WB_REQ};
          if (LS_EFF == 1) begin
            // Single bubble: the dependent instruction is released next cycle
            arm     = 1'b1;
            arm_val = {FRWD_RS1_WB_REQ, FRWD_RS2_WB_REQ};
          end else begin
            bcnt_d  = LS_LOAD;
            state_d = ST_LOAD_STALL;
          end
        end
      end
      ST_LOAD_STALL: begin
        // EX holds a bubble, so new requests cannot be genuine
        ctrl_run = CTRL_LOAD;
        bcnt_d   = bcnt_q - 1'b1;
        if (bcnt_q == STALL_CTR_W'(1)) begin
          state_d = ST_RUN;
          arm     = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (MDU_DONE) begin
          ctrl_run = CTRL_FLOW;
          state_d  = ST_RUN;
        end else begin
          ctrl_run = CTRL_MDU;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    frwd_d = arm ? arm_val : 2'b00;
  end

  // Reset holds every stage frozen and NOP-filled regardless of state
  always_comb begin
    ctrl = RESET_N ? ctrl_run : CTRL_RESET;
  end

  // Control-path registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      bcnt_q  <= '0;
      hold_q  <= 2'b00;
      frwd_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      hold_q  <= hold_d;
      frwd_q  <= frwd_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_inc   (~ctrl.pc_en),
    .i_clear (1'b0),
    .o_count (stall_cnt)
  );

  assign PC_EN        = ctrl.pc_en;
  assign IF_ID_EN     = ctrl.if_id_en;
  assign IF_ID_FLUSH  = ctrl.if_id_flush;
  assign ID_EX_EN     = ctrl.id_ex_en;
  assign ID_EX_FLUSH  = ctrl.id_ex_flush;
  assign EX_MEM_FLUSH = ctrl.ex_mem_flush;
  assign FRWD_RS1_WB  = frwd_q[1];
  assign FRWD_RS2_WB  = frwd_q[0];
  assign STALL_CNT    = stall_cnt;
  assign STATE        = state_q;

endmodule : pipeline_stall_ctrl
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Brief    : Self-checking bench; three instances (L=1/W=16, L=3/W=4,
//            L=2/W=8) share one stimulus stream and are compared against a
//            cycle-level behavioural model every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  localparam int NI = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET_N, BUBBLE_REQ, RQ1, RQ2, MS, MD, BR;

  logic       pc_en[NI], if_id_en[NI], if_id_fl[NI], id_ex_en[NI], id_ex_fl[NI], ex_mem_fl[NI];
  logic       f1[NI], f2[NI];
  logic [1:0] st[NI];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  cnt2;

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .BUBBLE_REQ(BUBBLE_REQ),
    .FRWD_RS1_WB_REQ(RQ1), .FRWD_RS2_WB_REQ(RQ2), .MDU_START(MS), .MDU_DONE(MD),
    .BRANCH_TAKEN(BR), .PC_EN(pc_en[0]), .IF_ID_EN(if_id_en[0]), .IF_ID_FLUSH(if_id_fl[0]),
    .ID_EX_EN(id_ex_en[0]), .ID_EX_FLUSH(id_ex_fl[0]), .EX_MEM_FLUSH(ex_mem_fl[0]),
    .FRWD_RS1_WB(f1[0]), .FRWD_RS2_WB(f2[0]), .STALL_CNT(cnt0), .STATE(st[0]));

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .BUBBLE_REQ(BUBBLE_REQ),
    .FRWD_RS1_WB_REQ(RQ1), .FRWD_RS2_WB_REQ(RQ2), .MDU_START(MS), .MDU_DONE(MD),
    .BRANCH_TAKEN(BR), .PC_EN(pc_en[1]), .IF_ID_EN(if_id_en[1]), .IF_ID_FLUSH(if_id_fl[1]),
    .ID_EX_EN(id_ex_en[1]), .ID_EX_FLUSH(id_ex_fl[1]), .EX_MEM_FLUSH(ex_mem_fl[1]),
    .FRWD_RS1_WB(f1[1]), .FRWD_RS2_WB(f2[1]), .STALL_CNT(cnt1), .STATE(st[1]));

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(8)) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .BUBBLE_REQ(BUBBLE_REQ),
    .FRWD_RS1_WB_REQ(RQ1), .FRWD_RS2_WB_REQ(RQ2), .MDU_START(MS), .MDU_DONE(MD),
    .BRANCH_TAKEN(BR), .PC_EN(pc_en[2]), .IF_ID_EN(if_id_en[2]), .IF_ID_FLUSH(if_id_fl[2]),
    .ID_EX_EN(id_ex_en[2]), .ID_EX_FLUSH(id_ex_fl[2]), .EX_MEM_FLUSH(ex_mem_fl[2]),
    .FRWD_RS1_WB(f1[2]), .FRWD_RS2_WB(f2[2]), .STALL_CNT(cnt2), .STATE(st[2]));

  // ---------------- behavioural model ----------------
  int ls_tab[NI]   = '{1, 3, 2};
  int cmax_tab[NI] = '{65535, 15, 255};

  int       m_left[NI], n_left[NI];   // bubbles still to insert after this cycle
  bit       m_mw[NI],   n_mw[NI];     // waiting for the MDU
  bit [1:0] m_hold[NI], n_hold[NI];   // {rs1, rs2} captured requests
  bit [1:0] m_fwd[NI],  n_fwd[NI];    // {rs1, rs2} forward selects now visible
  int       m_cnt[NI],  n_cnt[NI];
  bit [5:0] ex_ctl[NI];               // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_fl}

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < NI; k++) begin
      bit       arm;
      bit [1:0] av;
      bit [5:0] c;
      if (!RESET_N) begin
        m_left[k] = 0; m_mw[k] = 0; m_hold[k] = 0; m_fwd[k] = 0; m_cnt[k] = 0;
        n_left[k] = 0; n_mw[k] = 0; n_hold[k] = 0; n_fwd[k] = 0; n_cnt[k] = 0;
        ex_ctl[k] = 6'b001111;
      end else begin
        arm = 0; av = m_hold[k];
        n_left[k] = m_left[k]; n_mw[k] = m_mw[k]; n_hold[k] = m_hold[k];
        if (m_mw[k]) begin
          if (MD) begin c = 6'b110100; n_mw[k] = 0; end
          else        c = 6'b000001;
        end else if (m_left[k] > 0) begin
          c = 6'b000110;
          n_left[k] = m_left[k] - 1;
          if (n_left[k] == 0) arm = 1;
        end else if (BR) begin
          c = 6'b111110;
        end else if (MS && !MD) begin
          c = 6'b000001; n_mw[k] = 1;
        end else if (MS) begin
          c = 6'b110100;
        end else if (BUBBLE_REQ) begin
          c = 6'b000110;
          n_hold[k] = {RQ1, RQ2};
          if (ls_tab[k] == 1) begin arm = 1; av = {RQ1, RQ2}; end
          else n_left[k] = ls_tab[k] - 1;
        end else begin
          c = 6'b110100;
        end
        ex_ctl[k] = c;
        n_fwd[k]  = arm ? av : 2'b00;
        n_cnt[k]  = (!c[5] && m_cnt[k] < cmax_tab[k]) ? m_cnt[k] + 1 : m_cnt[k];
      end
    end
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < NI; k++) begin
      m_left[k] = n_left[k]; m_mw[k] = n_mw[k]; m_hold[k] = n_hold[k];
      m_fwd[k]  = n_fwd[k];  m_cnt[k] = n_cnt[k];
    end
  endfunction

  function automatic int exp_outs(input int k);
    bit [1:0] s;
    s = m_mw[k] ? 2'b10 : (m_left[k] > 0 ? 2'b01 : 2'b00);
    return int'({ex_ctl[k], m_fwd[k], s});
  endfunction

  function automatic int act_outs(input int k);
    return int'({pc_en[k], if_id_en[k], if_id_fl[k], id_ex_en[k], id_ex_fl[k],
                 ex_mem_fl[k], f1[k], f2[k], st[k]});
  endfunction

  function automatic int act_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // Every-cycle comparison against the model, half a cycle away from the edge
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("outs%0d", k), act_outs(k), exp_outs(k));
        chk($sformatf("stall_cnt%0d", k), act_cnt(k), m_cnt[k]);
      end
    end
  end

  task automatic drive(input bit rst, input bit bub, input bit r1, input bit r2,
                       input bit ms, input bit md, input bit br);
    RESET_N = rst; BUBBLE_REQ = bub; RQ1 = r1; RQ2 = r2; MS = ms; MD = md; BR = br;
    model_eval();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    model_commit();
  endtask

  task automatic reset_seq();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_pc0, n_st1, fwd_at, n_md;
    RESET_N = 0; BUBBLE_REQ = 0; RQ1 = 0; RQ2 = 0; MS = 0; MD = 0; BR = 0;

    // Reset-held outputs
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    #1;
    chk("rst_pc_en", pc_en[0], 0);
    chk("rst_if_id_en", if_id_en[0], 0);
    chk("rst_id_ex_en", id_ex_en[0], 1);
    chk("rst_flushes", {if_id_fl[0], id_ex_fl[0], ex_mem_fl[0]}, 3'b111);
    chk("rst_cnt", cnt0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    // Load-use with L=1 and an RS2 forward request
    drive(1, 1, 0, 1, 0, 0, 0);
    #1;
    chk("lu1_pc_en", pc_en[0], 0);
    chk("lu1_id_ex_flush", id_ex_fl[0], 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lu1_frwd_rs2", f2[0], 1);
    chk("lu1_frwd_rs1", f1[0], 0);
    chk("lu1_stall_cnt", cnt0, 1);
    tick();

    // Load-use with L=3
    reset_seq();
    n_pc0 = 0; n_st1 = 0; fwd_at = -1;
    for (int i = 0; i < 6; i++) begin
      drive(1, (i == 0), 1, 1, 0, 0, 0);
      #1;
      if (!pc_en[1]) n_pc0++;
      if (st[1] == 2'b01) n_st1++;
      if (f1[1] && fwd_at < 0) fwd_at = i;
      tick();
    end
    chk("lu3_pc_low_cycles", n_pc0, 3);
    chk("lu3_state01_cycles", n_st1, 2);
    chk("lu3_fwd_cycle", fwd_at, 3);

    // MDU with DONE 33 cycles after START
    reset_seq();
    n_md = 0;
    for (int i = 0; i < 33; i++) begin
      drive(1, 0, 0, 0, (i == 0), 0, 0);
      #1;
      if (!pc_en[0] && !id_ex_en[0]) n_md++;
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    #1;
    chk("mdu_done_pc_en", pc_en[0], 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mdu_stall_cycles", n_md, 33);
    chk("mdu_stall_cnt", cnt0, 33);
    chk("mdu_state_run", st[0], 0);
    tick();

    // Branch, bubble and MDU start together
    reset_seq();
    drive(1, 1, 1, 1, 1, 0, 1);
    #1;
    chk("br_flushes", {if_id_fl[0], id_ex_fl[0]}, 2'b11);
    chk("br_pc_en", pc_en[0], 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_state", st[0], 0);
    chk("br_no_fwd", {f1[0], f2[0]}, 2'b00);
    tick();

    // Asynchronous reset in the middle of MDU_WAIT
    reset_seq();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("arst_state", st[0], 0);
    chk("arst_cnt", cnt0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();

    // Saturation of the 4-bit counter with 20 stall cycles
    reset_seq();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, (i == 0), 0, 0); tick();
    end
    drive(1, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_cnt_w4", cnt1, 15);
    chk("sat_cnt_w16", cnt0, 20);
    tick();

    // Randomised traffic
    reset_seq();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0));
      tick();
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl
`default_nettype wire
